excp_ctrl: RTL and testbench
============================

// Module: excp_ctrl
// PURPOSE
//  Exception/interrupt sequencer between the MEM stage and CP0.
//  Prioritises MEM-stage exception flags and masked hardware/timer interrupts.
//  Issues one exception_type to CP0 per accepted event, then flushes the pipeline
//  and redirects the PC to EXC_VECTOR, or to EPC for ERET.
//  Stalls the MEM stage while a flush sequence is in progress.
// PARAMETERS
//  EXC_VECTOR    32'hBFC0_0380  redirect target for all exceptions/interrupts
//  FLUSH_CYCLES  2              cycles flush_o stays high (1..7)
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous active-high reset
//  mem_valid_i      in   1   MEM stage holds a real (non-bubble) instruction
//  mem_flags_i      in   4   {eret, ov, invalid_inst, syscall}
//  mem_pc_i         in   32  PC of MEM instruction
//  mem_delay_i      in   1   MEM instruction is in a delay slot
//  status_i         in   32  CP0 Status (IE=bit0, EXL=bit1, IM=bits15:8)
//  cause_i          in   32  CP0 Cause (IP=bits15:8)
//  epc_i            in   32  CP0 EPC
//  int_i            in   6   external hardware interrupt lines, level
//  timer_int_i      in   1   CP0 timer interrupt, level
//  excp_type_o      out  32  to CP0: 1 int, 8 syscall, 10 invalid, 12 ov, 14 eret, 0 none
//  excp_pc_o        out  32  to CP0 pc_i
//  excp_delay_o     out  1   to CP0 is_in_delayslot_i
//  hw_int_o         out  6   sampled int lines to CP0 (bit5 ORed with timer_int_i)
//  flush_o          out  1   flush IF..MEM
//  new_pc_o         out  32  redirect target; valid while flush_o=1
//  stall_o          out  1   hold MEM/WB; high in COMMIT and FLUSH
// BEHAVIOUR
//  - Reset values: all outputs 0. State resets to IDLE. Flush counter resets to 0.
//  - Interrupt pending: IE=1 && EXL=0 && |(cause_i[15:8] & status_i[15:8]).
//    Also pending if hw_int_o-derived bits & IM are nonzero.
//  - Priority (high->low): interrupt, invalid_inst, syscall, ov, eret.
//    Only one event is accepted at a time.
//  - Flags are ignored unless mem_valid_i=1.
//  - An interrupt is accepted only when mem_valid_i=1, giving a precise EPC.
//  - Non-interrupt exceptions are still forwarded when EXL=1; CP0 decides whether
//    EPC is updated. ERET is always forwarded.
//  - FSM
//    IDLE:   on an accepted event, register type/pc/delay, drive excp_type_o for
//            exactly 1 cycle, go to COMMIT.
//    COMMIT: excp_type_o=0, flush_o=1, latch new_pc_o, load counter=FLUSH_CYCLES-1,
//            go to FLUSH. If FLUSH_CYCLES=1, go directly to IDLE.
//    FLUSH:  flush_o=1; decrement counter; at 0 go to IDLE.
//  - new_pc_o is EXC_VECTOR, or epc_i sampled in COMMIT for ERET.
//    This is the cycle after CP0 absorbs the event.
//  - stall_o=1 in COMMIT and FLUSH. Events arriving then are dropped, because
//    flush kills them; int lines stay level and are re-evaluated in IDLE.
//  - Latency: event at cycle N -> excp_type_o at N+1 -> flush_o/new_pc_o at
//    N+2 .. N+1+FLUSH_CYCLES.
//  - Reset mid-sequence returns to IDLE next edge; flush_o drops immediately on that edge.
//  - excp_pc_o = mem_pc_i unmodified; CP0 applies the delay-slot -4.
// CONFIGURATION
//  EXCP_CTRL_INT_SYNC_EN defined: int_i passes a 2-flop synchronizer;
//    hw_int_o lags int_i by 2 cycles.
//  Not defined: a single register stage; hw_int_o lags int_i by 1 cycle.
//  timer_int_i is never synchronized in either case.
// TESTING
//  1 syscall: flags=4'b0001, valid, pc=32'h8000_0010
//    -> excp_type_o=8 for 1 cycle, excp_pc_o=32'h8000_0010;
//       flush_o high 2 cycles, new_pc_o=32'hBFC0_0380.
//  2 eret: flags=4'b1000, epc_i=32'h8000_0100 -> excp_type_o=14, new_pc_o=32'h8000_0100.
//  3 priority: flags=4'b0110 with IE=1, IM[2]=1, cause IP[2]=1 -> excp_type_o=1 only;
//    no second event after the flush.
//  4 masking: int_i[0]=1, status=32'h0000_0403 (EXL=1) -> no event.
//    Clear EXL -> interrupt accepted on the next valid instruction.
//  5 delay slot: ov with mem_delay_i=1, pc=32'h8000_0024
//    -> excp_type_o=12, excp_delay_o=1, excp_pc_o=32'h8000_0024.
//  6 rst asserted during FLUSH -> flush_o=0 and stall_o=0 next cycle;
//    a fresh syscall then completes normally. Run with and without EXCP_CTRL_INT_SYNC_EN.

Source files
------------

// File: rtl/excp_ctrl.sv
// rtl/excp_ctrl.sv - exception/interrupt sequencer between the MEM stage and CP0
// Optional macro EXCP_CTRL_INT_SYNC_EN: 2-flop synchronizer on int_i (default: single register stage).
module excp_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [3:0]  mem_flags_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_delay_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  output logic [31:0] excp_type_o,
  output logic [31:0] excp_pc_o,
  output logic        excp_delay_o,
  output logic [5:0]  hw_int_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_o
);

  localparam logic [31:0] TYPE_INT  = 32'd1;
  localparam logic [31:0] TYPE_SYS  = 32'd8;
  localparam logic [31:0] TYPE_INV  = 32'd10;
  localparam logic [31:0] TYPE_OV   = 32'd12;
  localparam logic [31:0] TYPE_ERET = 32'd14;
  localparam logic [2:0]  CNT_LOAD  = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_FLUSH} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_type, w_type_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_delay, w_delay_nxt;
  logic        r_flush, w_flush_nxt;
  logic [31:0] r_new_pc, w_new_pc_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [5:0]  r_hw_int;
  logic [5:0]  w_int_stage;
  logic [7:0]  w_ip;
  logic        w_int_pend;
  logic        w_accept;
  logic [31:0] w_evt_type;
  logic        w_unused;

`ifdef EXCP_CTRL_INT_SYNC_EN
  logic [5:0] r_int_meta;
  always_ff @(posedge clk) begin
    if (rst) r_int_meta <= '0;
    else     r_int_meta <= int_i;
  end
  assign w_int_stage = r_int_meta;
`else
  assign w_int_stage = int_i;
`endif

  // Timer bypasses the synchronizer: it is already in this clock domain.
  always_ff @(posedge clk) begin
    if (rst) r_hw_int <= '0;
    else     r_hw_int <= {w_int_stage[5] | timer_int_i, w_int_stage[4:0]};
  end

  assign w_ip       = cause_i[15:8] | {r_hw_int, 2'b00};
  assign w_int_pend = status_i[0] & ~status_i[1] & (|(w_ip & status_i[15:8]));
  assign w_accept   = mem_valid_i & ~r_flush & (w_int_pend | (|mem_flags_i));
  assign w_unused   = &{1'b0, status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  always_comb begin
    w_evt_type = TYPE_ERET;
    if (w_int_pend)          w_evt_type = TYPE_INT;
    else if (mem_flags_i[1]) w_evt_type = TYPE_INV;
    else if (mem_flags_i[0]) w_evt_type = TYPE_SYS;
    else if (mem_flags_i[2]) w_evt_type = TYPE_OV;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_type_nxt   = '0;
    w_pc_nxt     = r_pc;
    w_delay_nxt  = r_delay;
    w_flush_nxt  = 1'b0;
    w_new_pc_nxt = r_new_pc;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_COMMIT;
          w_type_nxt  = w_evt_type;
          w_pc_nxt    = mem_pc_i;
          w_delay_nxt = mem_delay_i;
        end
      end
      S_COMMIT: begin
        // r_type still holds the event CP0 absorbed this cycle.
        w_flush_nxt  = 1'b1;
        w_new_pc_nxt = (r_type == TYPE_ERET) ? epc_i : EXC_VECTOR;
        w_cnt_nxt    = CNT_LOAD;
        w_state_nxt  = (CNT_LOAD == 3'd0) ? S_IDLE : S_FLUSH;
      end
      S_FLUSH: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_flush_nxt = 1'b1;
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_type   <= '0;
      r_pc     <= '0;
      r_delay  <= 1'b0;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_type   <= w_type_nxt;
      r_pc     <= w_pc_nxt;
      r_delay  <= w_delay_nxt;
      r_flush  <= w_flush_nxt;
      r_new_pc <= w_new_pc_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign excp_type_o  = r_type;
  assign excp_pc_o    = r_pc;
  assign excp_delay_o = r_delay;
  assign hw_int_o     = r_hw_int;
  assign flush_o      = r_flush;
  assign new_pc_o     = r_new_pc;
  assign stall_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_excp_ctrl.sv
// tb/tb_excp_ctrl.sv - self-checking bench for excp_ctrl with a cycle-offset reference model
module tb_excp_ctrl;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int FC = 2;
`ifdef EXCP_CTRL_INT_SYNC_EN
  localparam int INT_LAG = 2;
`else
  localparam int INT_LAG = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_valid_i, mem_delay_i, timer_int_i;
  logic [3:0]  mem_flags_i;
  logic [31:0] mem_pc_i, status_i, cause_i, epc_i;
  logic [5:0]  int_i;
  logic [31:0] excp_type_o, excp_pc_o, new_pc_o;
  logic        excp_delay_o, flush_o, stall_o;
  logic [5:0]  hw_int_o;

  excp_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_flags_i(mem_flags_i),
    .mem_pc_i(mem_pc_i), .mem_delay_i(mem_delay_i), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .int_i(int_i), .timer_int_i(timer_int_i), .excp_type_o(excp_type_o),
    .excp_pc_o(excp_pc_o), .excp_delay_o(excp_delay_o), .hw_int_o(hw_int_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .stall_o(stall_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: everything is expressed as an offset d from the cycle the last event was accepted.
  bit          has_acc = 1'b0;
  int          acc_cyc = 0;
  logic [31:0] m_type = '0, m_pc = '0, m_newpc = '0;
  logic        m_delay = 1'b0;
  logic [5:0]  ih0 = '0, ih1 = '0;
  logic        th1 = 1'b0;

  logic [31:0] e_type, e_pc, e_newpc, s_type, s_pc, s_newpc;
  logic        e_delay, e_flush, e_stall, s_delay, s_flush, s_stall;
  logic [5:0]  e_hw, s_hw;

  task automatic tick();
    int d;
    logic [5:0] lagged;
    logic [7:0] ip;
    logic       ipend;
    d       = cyc - acc_cyc;
    lagged  = (INT_LAG == 2) ? ih1 : ih0;
    e_hw    = {lagged[5] | th1, lagged[4:0]};
    e_type  = (has_acc && d == 1) ? m_type : 32'd0;
    e_pc    = m_pc;
    e_delay = m_delay;
    e_newpc = m_newpc;
    e_stall = has_acc && d >= 1 && d <= 1 + FC;
    e_flush = has_acc && d >= 2 && d <= 1 + FC;
    @(negedge clk);
    s_type = excp_type_o; s_pc = excp_pc_o; s_delay = excp_delay_o; s_hw = hw_int_o;
    s_flush = flush_o; s_newpc = new_pc_o; s_stall = stall_o;
    if (rst) begin
      has_acc = 1'b0; m_type = '0; m_pc = '0; m_delay = 1'b0; m_newpc = '0;
      ih0 = '0; ih1 = '0; th1 = 1'b0;
    end else begin
      if (has_acc && d == 1) m_newpc = (m_type == 32'd14) ? epc_i : VEC;
      ip    = cause_i[15:8] | {e_hw, 2'b00};
      ipend = status_i[0] && !status_i[1] && ((ip & status_i[15:8]) != 8'h00);
      if (mem_valid_i && !(has_acc && d <= 1 + FC) && (ipend || mem_flags_i != 4'h0)) begin
        if (ipend)               m_type = 32'd1;
        else if (mem_flags_i[1]) m_type = 32'd10;
        else if (mem_flags_i[0]) m_type = 32'd8;
        else if (mem_flags_i[2]) m_type = 32'd12;
        else                     m_type = 32'd14;
        m_pc = mem_pc_i; m_delay = mem_delay_i; has_acc = 1'b1; acc_cyc = cyc;
      end
      ih1 = ih0; ih0 = int_i; th1 = timer_int_i;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    rst = 1'b0; mem_valid_i = 1'b0; mem_flags_i = '0; mem_pc_i = '0; mem_delay_i = 1'b0;
    status_i = '0; cause_i = '0; int_i = '0; timer_int_i = 1'b0;
  endtask

  task automatic drain();
    set_idle();
    repeat (5) tick();
  endtask

  task automatic test_reset();
    set_idle();
    epc_i = '0;
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (s_type !== 32'd0)  begin n_fail++; $display("FAIL reset_type: got %h want 0", s_type); end
    n_tests++; if (s_pc !== 32'd0)    begin n_fail++; $display("FAIL reset_pc: got %h want 0", s_pc); end
    n_tests++; if (s_delay !== 1'b0)  begin n_fail++; $display("FAIL reset_delay: got %b want 0", s_delay); end
    n_tests++; if (s_hw !== 6'd0)     begin n_fail++; $display("FAIL reset_hw_int: got %h want 0", s_hw); end
    n_tests++; if (s_flush !== 1'b0)  begin n_fail++; $display("FAIL reset_flush: got %b want 0", s_flush); end
    n_tests++; if (s_newpc !== 32'd0) begin n_fail++; $display("FAIL reset_new_pc: got %h want 0", s_newpc); end
    n_tests++; if (s_stall !== 1'b0)  begin n_fail++; $display("FAIL reset_stall: got %b want 0", s_stall); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_syscall();
    int nflush;
    set_idle();
    mem_valid_i = 1'b1; mem_flags_i = 4'b0001; mem_pc_i = 32'h8000_0010;
    tick();
    set_idle();
    tick();
    n_tests++; if (s_type !== 32'd8) begin n_fail++; $display("FAIL syscall_type: got %0d want 8", s_type); end
    n_tests++; if (s_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL syscall_pc: got %h want 80000010", s_pc); end
    n_tests++; if (s_stall !== 1'b1 || s_flush !== 1'b0) begin n_fail++; $display("FAIL syscall_commit: stall=%b flush=%b want 1/0", s_stall, s_flush); end
    tick();
    n_tests++; if (s_newpc !== VEC) begin n_fail++; $display("FAIL syscall_new_pc: got %h want %h", s_newpc, VEC); end
    n_tests++; if (s_type !== 32'd0) begin n_fail++; $display("FAIL syscall_type_1cyc: got %0d want 0", s_type); end
    nflush = (s_flush === 1'b1) ? 1 : 0;
    repeat (3) begin
      tick();
      if (s_flush === 1'b1) nflush++;
    end
    n_tests++; if (nflush != FC) begin n_fail++; $display("FAIL syscall_flush_len: got %0d want %0d", nflush, FC); end
    n_tests++; if (s_stall !== 1'b0) begin n_fail++; $display("FAIL syscall_stall_end: got %b want 0", s_stall); end
    drain();
  endtask

  task automatic test_eret();
    set_idle();
    epc_i = 32'h8000_0100;
    mem_valid_i = 1'b1; mem_flags_i = 4'b1000; mem_pc_i = 32'h8000_0050;
    tick();
    set_idle();
    tick();
    n_tests++; if (s_type !== 32'd14) begin n_fail++; $display("FAIL eret_type: got %0d want 14", s_type); end
    tick();
    n_tests++; if (s_newpc !== 32'h8000_0100 || s_flush !== 1'b1) begin n_fail++; $display("FAIL eret_new_pc: got %h flush=%b want 80000100 flush=1", s_newpc, s_flush); end
    drain();
  endtask

  task automatic test_priority();
    int nevt;
    set_idle();
    status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
    mem_valid_i = 1'b1; mem_flags_i = 4'b0110; mem_pc_i = 32'h8000_0070;
    tick();
    mem_valid_i = 1'b0; status_i = 32'h0000_0403;
    tick();
    n_tests++; if (s_type !== 32'd1) begin n_fail++; $display("FAIL priority_type: got %0d want 1", s_type); end
    nevt = 0;
    repeat (6) begin
      tick();
      if (s_type !== 32'd0) nevt++;
    end
    n_tests++; if (nevt != 0) begin n_fail++; $display("FAIL priority_second_event: got %0d events want 0", nevt); end
    drain();
  endtask

  task automatic test_masking();
    int nevt;
    set_idle();
    int_i = 6'b000001; status_i = 32'h0000_0403; mem_valid_i = 1'b1;
    nevt = 0;
    repeat (5) begin
      tick();
      if (s_type !== 32'd0) nevt++;
    end
    n_tests++; if (nevt != 0) begin n_fail++; $display("FAIL masking_exl: got %0d events want 0", nevt); end
    n_tests++; if (s_hw !== 6'b000001) begin n_fail++; $display("FAIL masking_hw_int: got %b want 000001", s_hw); end
    status_i = 32'h0000_0401; mem_pc_i = 32'h8000_0090;
    tick();
    mem_valid_i = 1'b0; status_i = 32'h0000_0403; int_i = '0;
    tick();
    n_tests++; if (s_type !== 32'd1 || s_pc !== 32'h8000_0090) begin n_fail++; $display("FAIL masking_accept: got type %0d pc %h want 1 80000090", s_type, s_pc); end
    drain();
  endtask

  task automatic test_delay_slot();
    set_idle();
    mem_valid_i = 1'b1; mem_flags_i = 4'b0100; mem_delay_i = 1'b1; mem_pc_i = 32'h8000_0024;
    tick();
    set_idle();
    tick();
    n_tests++; if (s_type !== 32'd12) begin n_fail++; $display("FAIL delay_type: got %0d want 12", s_type); end
    n_tests++; if (s_delay !== 1'b1) begin n_fail++; $display("FAIL delay_flag: got %b want 1", s_delay); end
    n_tests++; if (s_pc !== 32'h8000_0024) begin n_fail++; $display("FAIL delay_pc: got %h want 80000024", s_pc); end
    drain();
  endtask

  task automatic test_reset_mid_flush();
    int nflush;
    set_idle();
    mem_valid_i = 1'b1; mem_flags_i = 4'b0001; mem_pc_i = 32'h8000_0030;
    tick();
    set_idle();
    tick();
    rst = 1'b1;
    tick();
    n_tests++; if (s_flush !== 1'b1) begin n_fail++; $display("FAIL midrst_in_flush: got %b want 1", s_flush); end
    rst = 1'b0;
    tick();
    n_tests++; if (s_flush !== 1'b0 || s_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_drop: flush=%b stall=%b want 0/0", s_flush, s_stall); end
    mem_valid_i = 1'b1; mem_flags_i = 4'b0001; mem_pc_i = 32'h8000_0040;
    tick();
    set_idle();
    tick();
    n_tests++; if (s_type !== 32'd8 || s_pc !== 32'h8000_0040) begin n_fail++; $display("FAIL midrst_fresh: got type %0d pc %h want 8 80000040", s_type, s_pc); end
    nflush = 0;
    repeat (4) begin
      tick();
      if (s_flush === 1'b1) nflush++;
    end
    n_tests++; if (nflush != FC) begin n_fail++; $display("FAIL midrst_flush_len: got %0d want %0d", nflush, FC); end
    drain();
  endtask

  task automatic test_random();
    set_idle();
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(0, 149) == 0);
      mem_valid_i = ($urandom_range(0, 3) != 0);
      mem_flags_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      mem_pc_i    = $urandom;
      mem_delay_i = 1'($urandom_range(0, 1));
      epc_i       = $urandom;
      if ($urandom_range(0, 15) == 0)
        status_i = {16'($urandom), 8'($urandom), 6'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)};
      if ($urandom_range(0, 15) == 0)
        cause_i = {16'($urandom), (($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00), 8'($urandom)};
      if ($urandom_range(0, 9) == 0) int_i[$urandom_range(0, 5)] = ~int_i[$urandom_range(0, 5)];
      if ($urandom_range(0, 19) == 0) timer_int_i = ~timer_int_i;
      tick();
      n_tests++; if (s_type !== e_type)   begin n_fail++; $display("FAIL rnd_type c%0d: got %0d want %0d", cyc, s_type, e_type); end
      n_tests++; if (s_pc !== e_pc)       begin n_fail++; $display("FAIL rnd_pc c%0d: got %h want %h", cyc, s_pc, e_pc); end
      n_tests++; if (s_delay !== e_delay) begin n_fail++; $display("FAIL rnd_delay c%0d: got %b want %b", cyc, s_delay, e_delay); end
      n_tests++; if (s_hw !== e_hw)       begin n_fail++; $display("FAIL rnd_hw_int c%0d: got %b want %b", cyc, s_hw, e_hw); end
      n_tests++; if (s_flush !== e_flush) begin n_fail++; $display("FAIL rnd_flush c%0d: got %b want %b", cyc, s_flush, e_flush); end
      n_tests++; if (s_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, s_stall, e_stall); end
      if (e_flush) begin
        n_tests++; if (s_newpc !== e_newpc) begin n_fail++; $display("FAIL rnd_new_pc c%0d: got %h want %h", cyc, s_newpc, e_newpc); end
      end
    end
    drain();
  endtask

  initial begin
    set_idle();
    epc_i = '0;
    test_reset();
    test_syscall();
    test_eret();
    test_priority();
    test_masking();
    test_delay_slot();
    test_reset_mid_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
